// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator (640x480@60 defaults).
package vga_timing_pkg;

   localparam int POS_W = 12;
   typedef logic [POS_W-1:0] pos_t;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FPORCH_DEF  = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BPORCH_DEF  = 48;

   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FPORCH_DEF  = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BPORCH_DEF  = 33;

   localparam int PREFETCH_DEF  = 32;

   function automatic int axis_total(input int visible, input int fporch,
                                     input int sync, input int bporch);
      return visible + fporch + sync + bporch;
   endfunction

   function automatic logic in_window(input pos_t p, input int lo, input int len);
      return (int'(p) >= lo) && (int'(p) < lo + len);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-enable in, timing/sync/position out; line_req present only with VGA_TIMING_LINE_REQ_EN.
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic pix_ena;
   logic hsync;
   logic vsync;
   logic vid_window;
   pos_t xpos;
   pos_t ypos;
   logic new_line;
   logic new_frame;
`ifdef VGA_TIMING_LINE_REQ_EN
   logic line_req;

   modport master (
      input  pix_ena,
      output hsync, vsync, vid_window, xpos, ypos, new_line, new_frame, line_req
   );
   modport slave (
      output pix_ena,
      input  hsync, vsync, vid_window, xpos, ypos, new_line, new_frame, line_req
   );
`else
   modport master (
      input  pix_ena,
      output hsync, vsync, vid_window, xpos, ypos, new_line, new_frame
   );
   modport slave (
      output pix_ena,
      input  hsync, vsync, vid_window, xpos, ypos, new_line, new_frame
   );
`endif
endinterface

// File: rtl/vga_timing_axis.sv
// One timing axis: wrapping position counter with registered sync and look-ahead visibility.
module vga_timing_axis
   import vga_timing_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_DEF,
   parameter int FPORCH  = H_FPORCH_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BPORCH  = H_BPORCH_DEF,
   parameter bit POL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   output pos_t pos,
   output logic last,
   output logic vis_next,
   output logic sync
);

   localparam int   TOTAL    = axis_total(VISIBLE, FPORCH, SYNC, BPORCH);
   localparam pos_t LAST_POS = pos_t'(TOTAL - 1);

   pos_t pos_nxt;
   pos_t pos_upd;
   logic sync_nxt;

   assign last     = (pos == LAST_POS);
   assign pos_nxt  = last ? '0 : pos + pos_t'(1);
   assign sync_nxt = in_window(pos_nxt, VISIBLE + FPORCH, SYNC);

   // Visibility of whatever position this axis holds after the current clock.
   assign pos_upd  = ena ? pos_nxt : pos;
   assign vis_next = (int'(pos_upd) < VISIBLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos  <= LAST_POS;
         sync <= ~POL;
      end else if (ena) begin
         pos  <= pos_nxt;
         sync <= sync_nxt ? POL : ~POL;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator driven by a pixel clock enable.
// Optional line prefetch request output enabled by macro VGA_TIMING_LINE_REQ_EN.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FPORCH  = H_FPORCH_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BPORCH  = H_BPORCH_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FPORCH  = V_FPORCH_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BPORCH  = V_BPORCH_DEF,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0
`ifdef VGA_TIMING_LINE_REQ_EN
   ,
   parameter int PREFETCH  = PREFETCH_DEF
`endif
) (
   input  logic             clk,
   input  logic             reset,
   vga_timing_gen_if.master vga
);

   logic [1:0] rst_pipe;
   logic       rst_int;

   pos_t h_pos, v_pos;
   logic h_last, v_last;
   logic h_vis_next, v_vis_next;
   logic h_sync, v_sync;
   logic v_ena;

   logic vid_window_q;
   logic new_line_q;
   logic new_frame_q;

   // Assert immediately, release two clk edges after reset drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rst_pipe <= 2'b11;
      else       rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst_int = rst_pipe[1];

   assign v_ena = vga.pix_ena & h_last;

   vga_timing_axis #(
      .VISIBLE (H_VISIBLE),
      .FPORCH  (H_FPORCH),
      .SYNC    (H_SYNC),
      .BPORCH  (H_BPORCH),
      .POL     (HS_POL)
   ) u_h_axis (
      .clk      (clk),
      .rst      (rst_int),
      .ena      (vga.pix_ena),
      .pos      (h_pos),
      .last     (h_last),
      .vis_next (h_vis_next),
      .sync     (h_sync)
   );

   vga_timing_axis #(
      .VISIBLE (V_VISIBLE),
      .FPORCH  (V_FPORCH),
      .SYNC    (V_SYNC),
      .BPORCH  (V_BPORCH),
      .POL     (VS_POL)
   ) u_v_axis (
      .clk      (clk),
      .rst      (rst_int),
      .ena      (v_ena),
      .pos      (v_pos),
      .last     (v_last),
      .vis_next (v_vis_next),
      .sync     (v_sync)
   );

`ifdef VGA_TIMING_LINE_REQ_EN
   localparam int   H_TOTAL  = axis_total(H_VISIBLE, H_FPORCH, H_SYNC, H_BPORCH);
   // Position one pixel before the request point, so the pulse lands as xpos reaches it.
   localparam pos_t LREQ_PRE = pos_t'((2 * H_TOTAL - PREFETCH - 1) % H_TOTAL);

   logic line_req_q;
   logic next_line_vis;

   assign next_line_vis = v_last ? (V_VISIBLE > 0) : ((int'(v_pos) + 1) < V_VISIBLE);
`endif

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         vid_window_q <= 1'b0;
         new_line_q   <= 1'b0;
         new_frame_q  <= 1'b0;
`ifdef VGA_TIMING_LINE_REQ_EN
         line_req_q   <= 1'b0;
`endif
      end else begin
         new_line_q  <= vga.pix_ena & h_last;
         new_frame_q <= vga.pix_ena & h_last & v_last;
         if (vga.pix_ena) vid_window_q <= h_vis_next & v_vis_next;
`ifdef VGA_TIMING_LINE_REQ_EN
         line_req_q  <= vga.pix_ena & (h_pos == LREQ_PRE) & next_line_vis;
`endif
      end
   end

   assign vga.xpos       = h_pos;
   assign vga.ypos       = v_pos;
   assign vga.hsync      = h_sync;
   assign vga.vsync      = v_sync;
   assign vga.vid_window = vid_window_q;
   assign vga.new_line   = new_line_q;
   assign vga.new_frame  = new_frame_q;
`ifdef VGA_TIMING_LINE_REQ_EN
   assign vga.line_req   = line_req_q;
`endif

endmodule
